// File: rtl/life_step.sv
// One Game-of-Life generation per start pulse: cells are scanned one per clock into a
// shadow grid, and the shadow grid is committed to data_out in a single edge at the end.
module life_step #(
  parameter int SIZE_X = 40,
  parameter int SIZE_Y = 30,
  parameter int WRAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [SIZE_X*SIZE_Y-1:0] load_data,
  input  logic                     start,
  output logic [SIZE_X*SIZE_Y-1:0] data_out,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              generation
);

  localparam int N  = SIZE_X * SIZE_Y;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int YW = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [N-1:0]    grid_q;
  logic [N-1:0]    shadow_q;
  logic [15:0]     gen_q;
  logic            done_q;
  logic            lastCell;
  logic [3:0]      nbrCount;
  logic            nextCell;

  assign lastCell = (idx_q == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !load) state_d = SCAN;
      SCAN:    if (lastCell) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Neighbour count for the cell under the scan pointer, always read from the committed grid.
  always_comb begin
    int            nx;
    int            ny;
    logic          inRange;
    logic [IW-1:0] addr;
    nx       = 0;
    ny       = 0;
    inRange  = 1'b0;
    addr     = '0;
    nbrCount = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx      = int'(x_q) + dx;
        ny      = int'(y_q) + dy;
        inRange = (dx != 0) || (dy != 0);
        if (nx < 0) begin
          nx = SIZE_X - 1;
          if (WRAP == 0) inRange = 1'b0;
        end else if (nx >= SIZE_X) begin
          nx = 0;
          if (WRAP == 0) inRange = 1'b0;
        end
        if (ny < 0) begin
          ny = SIZE_Y - 1;
          if (WRAP == 0) inRange = 1'b0;
        end else if (ny >= SIZE_Y) begin
          ny = 0;
          if (WRAP == 0) inRange = 1'b0;
        end
        addr = IW'(ny * SIZE_X + nx);
        if (inRange && grid_q[addr]) nbrCount = nbrCount + 4'd1;
      end
    end
    nextCell = (nbrCount == 4'd3) || (grid_q[idx_q] && (nbrCount == 4'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      grid_q   <= '0;
      shadow_q <= '0;
      gen_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == COMMIT);
      case (state_q)
        IDLE: begin
          if (load) begin
            grid_q <= load_data;
            gen_q  <= '0;
          end else if (start) begin
            idx_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
          end
        end
        SCAN: begin
          shadow_q[idx_q] <= nextCell;
          if (lastCell) begin
            idx_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
            if (x_q == XW'(SIZE_X - 1)) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        COMMIT: begin
          grid_q <= shadow_q;
          gen_q  <= gen_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_out   = grid_q;
  assign busy       = (state_q == SCAN) || (state_q == COMMIT);
  assign done       = done_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_step.sv
// Bench for life_step: a toroidal and a bounded instance run side by side against a
// grid-level Life model; expected generations are queued and checked whenever done pulses.
module tb_life_step;

  localparam int SX = 40;
  localparam int SY = 30;
  localparam int N  = SX * SY;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          start;
  logic [N-1:0]  loadData;
  logic [N-1:0]  dataWrap, dataFlat;
  logic          busyWrap, busyFlat;
  logic          doneWrap, doneFlat;
  logic [15:0]   genWrap, genFlat;

  always #5 clk = ~clk;

  life_step #(.SIZE_X(SX), .SIZE_Y(SY), .WRAP(1)) dutWrap (
    .clk(clk), .rst(rst), .load(load), .load_data(loadData), .start(start),
    .data_out(dataWrap), .busy(busyWrap), .done(doneWrap), .generation(genWrap)
  );

  life_step #(.SIZE_X(SX), .SIZE_Y(SY), .WRAP(0)) dutFlat (
    .clk(clk), .rst(rst), .load(load), .load_data(loadData), .start(start),
    .data_out(dataFlat), .busy(busyFlat), .done(doneFlat), .generation(genFlat)
  );

  typedef struct {
    logic [N-1:0] grid;
    logic [15:0]  gen;
  } exp_t;

  exp_t         expWrapQ[$];
  exp_t         expFlatQ[$];
  exp_t         eW, eF;
  int           total = 0;
  int           bad = 0;
  int           donePulses = 0;
  logic [N-1:0] modelWrap, modelFlat;
  logic [15:0]  modelGen;

  // Reference: apply the Life rule to a whole grid with modular or bounded neighbours.
  function automatic logic [N-1:0] lifeRule(input logic [N-1:0] g, input bit wrap);
    logic [N-1:0] r;
    int cnt, nx, ny;
    r = '0;
    for (int y = 0; y < SY; y++) begin
      for (int x = 0; x < SX; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            nx = x + dx;
            ny = y + dy;
            if (wrap) begin
              nx = (nx + SX) % SX;
              ny = (ny + SY) % SY;
            end else if (nx < 0 || nx >= SX || ny < 0 || ny >= SY) begin
              continue;
            end
            if (g[ny * SX + nx]) cnt++;
          end
        end
        r[y * SX + x] = (cnt == 3) || (g[y * SX + x] && cnt == 2);
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] randomGrid();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 2) == 0);
    return g;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkGrid(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    int firstDiff;
    total++;
    if (act !== exp) begin
      bad++;
      firstDiff = -1;
      for (int i = N - 1; i >= 0; i--) if (act[i] !== exp[i]) firstDiff = i;
      $display("[TB] FAIL %s: first differing cell %0d actual popcount=%0d required popcount=%0d",
               name, firstDiff, $countones(act), $countones(exp));
    end
  endtask

  task automatic pulse(input bit ld, input logic [N-1:0] d, input bit st);
    @(negedge clk);
    load     = ld;
    loadData = d;
    start    = st;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
  endtask

  task automatic pushStep();
    modelWrap = lifeRule(modelWrap, 1'b1);
    modelFlat = lifeRule(modelFlat, 1'b0);
    modelGen  = modelGen + 16'd1;
    expWrapQ.push_back('{grid: modelWrap, gen: modelGen});
    expFlatQ.push_back('{grid: modelFlat, gen: modelGen});
  endtask

  // Only used while both instances are idle, so the model can follow every pulse.
  task automatic applyStimulus(input bit ld, input logic [N-1:0] d, input bit st);
    pulse(ld, d, st);
    if (ld) begin
      modelWrap = d;
      modelFlat = d;
      modelGen  = 16'd0;
    end else if (st) begin
      pushStep();
    end
  endtask

  task automatic waitDone(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!doneWrap && cycles < N + 50);
    if (!doneWrap) checkOutput({name, " timeout"}, 0, 1);
  endtask

  task automatic doStep(input string name);
    int cycles;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput({name, " busy after start"}, int'(busyWrap), 1);
    waitDone(name, cycles);
    checkOutput({name, " latency"}, cycles, N + 1);
    checkOutput({name, " busy at done"}, int'(busyWrap), 0);
    @(negedge clk);
    checkOutput({name, " done width"}, int'(doneWrap), 0);
  endtask

  always @(negedge clk) begin
    if (doneWrap) begin
      donePulses++;
      if (expWrapQ.size() == 0) begin
        checkOutput("unexpected done wrap", 1, 0);
      end else begin
        eW = expWrapQ.pop_front();
        checkGrid("wrap grid", dataWrap, eW.grid);
        checkOutput("wrap generation", int'(genWrap), int'(eW.gen));
      end
    end
    if (doneFlat) begin
      if (expFlatQ.size() == 0) begin
        checkOutput("unexpected done flat", 1, 0);
      end else begin
        eF = expFlatQ.pop_front();
        checkGrid("flat grid", dataFlat, eF.grid);
        checkOutput("flat generation", int'(genFlat), int'(eF.gen));
      end
    end
  end

  initial begin
    logic [N-1:0] img, want, ones;
    int           d0, cycles;
    rst = 1'b1; load = 1'b0; start = 1'b0; loadData = '0;
    modelWrap = '0; modelFlat = '0; modelGen = '0;
    ones = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkGrid("reset data", dataWrap, '0);
    checkOutput("reset generation", int'(genWrap), 0);
    checkOutput("reset busy", int'(busyWrap), 0);
    checkOutput("reset done", int'(doneWrap), 0);

    // Blinker oscillates between vertical and horizontal.
    img = '0; img[165] = 1'b1; img[205] = 1'b1; img[245] = 1'b1;
    applyStimulus(1'b1, img, 1'b0);
    checkGrid("blinker load", dataWrap, img);
    doStep("blinker step1");
    want = '0; want[204] = 1'b1; want[205] = 1'b1; want[206] = 1'b1;
    checkGrid("blinker horizontal", dataWrap, want);
    checkOutput("blinker gen1", int'(genWrap), 1);
    doStep("blinker step2");
    checkGrid("blinker vertical", dataWrap, img);
    checkOutput("blinker gen2", int'(genWrap), 2);

    // Four corner cells form a block only on the torus.
    img = '0; img[0] = 1'b1; img[39] = 1'b1; img[1160] = 1'b1; img[1199] = 1'b1;
    applyStimulus(1'b1, img, 1'b0);
    doStep("corner");
    checkGrid("corner wrap", dataWrap, img);
    checkGrid("corner flat", dataFlat, '0);

    img = '0; img[41] = 1'b1; img[42] = 1'b1; img[81] = 1'b1; img[82] = 1'b1;
    applyStimulus(1'b1, img, 1'b0);
    d0 = donePulses;
    for (int i = 0; i < 3; i++) doStep("block");
    repeat (2) @(negedge clk);
    checkGrid("block still", dataWrap, img);
    checkOutput("block gen", int'(genWrap), 3);
    checkOutput("block done count", donePulses - d0, 3);

    // Load and start during a scan must be dropped, not queued.
    applyStimulus(1'b1, randomGrid(), 1'b0);
    d0 = donePulses;
    applyStimulus(1'b0, '0, 1'b1);
    repeat (497) @(negedge clk);
    pulse(1'b1, ones, 1'b1);
    waitDone("busy protect", cycles);
    repeat (N + 20) @(negedge clk);
    checkOutput("busy protect done count", donePulses - d0, 1);
    checkOutput("busy protect idle", int'(busyWrap), 0);

    img = randomGrid();
    applyStimulus(1'b1, img, 1'b1);
    checkOutput("load+start busy", int'(busyWrap), 0);
    repeat (3) @(negedge clk);
    checkGrid("load+start data", dataWrap, img);
    checkOutput("load+start gen", int'(genWrap), 0);
    checkOutput("load+start still idle", int'(busyWrap), 0);

    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, randomGrid(), 1'b0);
      doStep("random step");
      doStep("random step");
    end

    // Start issued in the same cycle done is high is honoured immediately.
    applyStimulus(1'b0, '0, 1'b1);
    waitDone("chain first", cycles);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pushStep();
    checkOutput("chain busy", int'(busyWrap), 1);
    waitDone("chain second", cycles);
    checkOutput("chain latency", cycles, N + 1);

    // Reset mid-scan aborts the step without a commit.
    repeat (3) @(negedge clk);
    d0 = donePulses;
    pulse(1'b0, '0, 1'b1);
    repeat (598) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midscan busy", int'(busyWrap), 0);
    checkGrid("midscan data", dataWrap, '0);
    checkOutput("midscan gen", int'(genWrap), 0);
    repeat (N + 20) @(negedge clk);
    checkOutput("midscan no done", donePulses - d0, 0);

    checkOutput("scoreboard drained", expWrapQ.size() + expFlatQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_step.md
LIFE_STEP -- requirements
Module: life_step

Interface
REQ-001 Parameter SIZE_X, default 40: grid width in cells.
REQ-002 Parameter SIZE_Y, default 30: grid height in cells.
REQ-003 Parameter WRAP, default 1: 1 = toroidal edges; 0 = cells outside the grid count as dead.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 load  input  1: one-cycle pulse; copy load_data into data_out.
REQ-007 load_data  input  SIZE_X*SIZE_Y: grid image written on load.
REQ-008 start  input  1: one-cycle pulse; compute one generation.
REQ-009 data_out  output  SIZE_X*SIZE_Y: current grid, bit index y*SIZE_X+x, 1 = live; drives the grid renderer's data input.
REQ-010 busy  output  1: high while a generation is being computed.
REQ-011 done  output  1: one-cycle pulse when data_out takes a new generation.
REQ-012 generation  output  16: count of committed generations.

Function
REQ-013 States: IDLE, SCAN, COMMIT; busy SHALL be 1 exactly when the state is SCAN or COMMIT.
REQ-014 In IDLE, load=1 SHALL write load_data into data_out on that edge and clear generation to 0; start is ignored on that edge (load wins).
REQ-015 In IDLE, start=1 with load=0 SHALL move to SCAN with cell index 0 and x=0, y=0.
REQ-016 In SCAN, one cell per clock in index order 0..N-1 (N=SIZE_X*SIZE_Y), x incrementing first, then y.
REQ-017 Per-cell rule: a 4-bit neighbour count over the 8 neighbours read from data_out; next = (count==3) | (live & count==2), written into an internal shadow register at the same index.
REQ-018 WRAP=1: x-1 at x=0 is SIZE_X-1, x+1 at SIZE_X-1 is 0; same for y. WRAP=0: out-of-range neighbours contribute 0.
REQ-019 data_out SHALL NOT change during SCAN or COMMIT; all cells read the pre-step generation.
REQ-020 After index N-1, move to COMMIT; on the COMMIT edge: data_out <= shadow, done <= 1, generation <= generation+1 (mod 2^16), state <= IDLE.
REQ-021 Latency: with start sampled at edge E0, data_out update and the rising edge of done occur at edge E0+N+1; done is high for exactly one cycle.
REQ-022 start or load while busy SHALL be ignored and SHALL NOT be queued.
REQ-023 start and done in the same cycle: start is honoured because the state is already IDLE.
REQ-024 Cell index, x and y counters are sized with $clog2 of N, SIZE_X and SIZE_Y; no combinational path from start or load to any output.

Reset
REQ-025 rst=1 SHALL, on the next edge and from any state, set state=IDLE, data_out=0, shadow=0, generation=0, busy=0, done=0, and index/x/y=0.
REQ-026 rst has priority over load and start; a step in progress is aborted without commit.

Verification (SIZE_X=40, SIZE_Y=30, N=1200)
REQ-027 Blinker: load bits {165,205,245}, then start -> busy for 1201 cycles, done pulse at E0+1201, data_out = bits {204,205,206} only, generation=1; a second start restores {165,205,245}, generation=2.
REQ-028 Corner block, WRAP=1: load bits {0,39,1160,1199}, then start -> data_out unchanged. Same image with WRAP=0 -> data_out = 0.
REQ-029 Block still life: load {41,42,81,82}, then 3 starts -> data_out unchanged, generation=3, exactly 3 done pulses.
REQ-030 Busy protection: start, then load=all-ones and a second start at cycle 500 -> result equals a single undisturbed step, exactly one done pulse.
REQ-031 Reset mid-scan: start, rst at cycle 600 -> next cycle busy=0, data_out=0, generation=0, no done pulse.
REQ-032 Simultaneous load and start in IDLE -> data_out = load_data, busy stays 0, generation=0.
